tsn_queue_rd_sched: RTL and testbench

//  Frame-granular read scheduler for NUM_Q egress queues. Each queue is one data sync_fifo
//  (standard mode, 1-cycle read latency) plus one length-descriptor sync_fifo (FWFT mode).

---
 rtl/tsn_queue_rd_sched.sv | 165 ++++++++++++++++
 tb/tb_tsn_queue_rd_sched.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsn_queue_rd_sched.sv
// Frame-granular read scheduler: selects an eligible egress queue, drains one frame onto a valid/ready stream.
// Strict priority by default; define TSN_QSCHED_RR_EN for round-robin selection.
`timescale 1ns/1ps
module tsn_queue_rd_sched #(
   parameter int NUM_Q = 4,
   parameter int WIDTH = 64,
   parameter int LEN_W = 12,
   parameter int QID_W = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [NUM_Q-1:0]       i_gate_open,
   input  logic [NUM_Q-1:0]       i_len_empty,
   input  logic [NUM_Q*LEN_W-1:0] i_len,
   output logic [NUM_Q-1:0]       o_len_rd,
   input  logic [NUM_Q-1:0]       i_data_empty,
   input  logic [NUM_Q*WIDTH-1:0] i_data,
   output logic [NUM_Q-1:0]       o_data_rd,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_last,
   output logic [QID_W-1:0]       o_qid,
   output logic                   o_busy,
   output logic                   o_err
);
   typedef enum logic {IDLE, XFER} state_t;
   typedef struct packed {
      logic [WIDTH-1:0] dat;
      logic             last;
      logic [QID_W-1:0] qid;
   } word_t;

   state_t           state_q, state_d;
   logic [QID_W-1:0] sel_q, sel_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             inflight_q, inflight_d;
   logic             tag_last_q, tag_last_d;
   logic [QID_W-1:0] tag_qid_q, tag_qid_d;
   word_t            skid_q [2];
   word_t            skid_d [2];
   logic             hd_q, hd_d;
   logic [1:0]       occ_q, occ_d;
`ifdef TSN_QSCHED_RR_EN
   logic [QID_W-1:0] last_gnt_q, last_gnt_d;
`endif

   logic [NUM_Q-1:0] elig;
   logic [QID_W-1:0] win;
   logic [LEN_W-1:0] win_len;
   logic             rd_en, credit, pop, push, skid_pop;
   word_t            in_word, out_word;

   always_comb begin
      int idx;
      idx  = 0;
      elig = i_gate_open & ~i_len_empty;
      win  = '0;
`ifdef TSN_QSCHED_RR_EN
      // Walk from farthest to nearest so the queue right after last_gnt wins.
      for (int i = NUM_Q - 1; i >= 0; i--) begin
         idx = (int'(last_gnt_q) + 1 + i) % NUM_Q;
         if (elig[idx]) win = QID_W'(idx);
      end
`else
      for (int i = 0; i < NUM_Q; i++) begin
         if (elig[i]) win = QID_W'(i);
      end
`endif
      win_len = i_len[int'(win)*LEN_W +: LEN_W];
   end

   // Words returning from the data FIFOs bypass the skid buffer when it is empty.
   always_comb begin
      in_word.dat  = i_data[int'(tag_qid_q)*WIDTH +: WIDTH];
      in_word.last = tag_last_q;
      in_word.qid  = tag_qid_q;
      out_word     = (occ_q != 2'd0) ? skid_q[hd_q] : in_word;
      o_valid      = (occ_q != 2'd0) | inflight_q;
      o_data       = o_valid ? out_word.dat  : '0;
      o_last       = o_valid ? out_word.last : 1'b0;
      o_qid        = o_valid ? out_word.qid  : '0;
      o_busy       = (state_q == XFER) | o_valid;
      pop          = o_valid & i_ready;
      skid_pop     = pop & (occ_q != 2'd0);
      push         = inflight_q & ~(pop & (occ_q == 2'd0));
      skid_d       = skid_q;
      if (push) skid_d[hd_q ^ occ_q[0]] = in_word;
      occ_d        = occ_q + 2'(push) - 2'(skid_pop);
      hd_d         = hd_q ^ skid_pop;
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      rem_d      = rem_q;
      o_len_rd   = '0;
      o_data_rd  = '0;
      o_err      = 1'b0;
      rd_en      = 1'b0;
`ifdef TSN_QSCHED_RR_EN
      last_gnt_d = last_gnt_q;
`endif
      credit = ({1'b0, occ_q} + 3'(inflight_q) - 3'(pop)) < 3'd2;
      case (state_q)
         IDLE: begin
            if ((elig != '0) && i_rst_n) begin
               o_len_rd[win] = 1'b1;
               if (win_len == '0) begin
                  o_err = 1'b1;
               end else begin
                  sel_d   = win;
                  rem_d   = win_len;
                  state_d = XFER;
`ifdef TSN_QSCHED_RR_EN
                  last_gnt_d = win;
`endif
               end
            end
         end
         default: begin
            rd_en = (rem_q != '0) && !i_data_empty[sel_q] && credit;
            o_data_rd[sel_q] = rd_en;
            if (rd_en) begin
               rem_d = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) state_d = IDLE;
            end
         end
      endcase
      inflight_d = rd_en;
      tag_last_d = rd_en ? (rem_q == LEN_W'(1)) : tag_last_q;
      tag_qid_d  = rd_en ? sel_q : tag_qid_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         rem_q      <= '0;
         inflight_q <= 1'b0;
         tag_last_q <= 1'b0;
         tag_qid_q  <= '0;
         skid_q[0]  <= '0;
         skid_q[1]  <= '0;
         hd_q       <= 1'b0;
         occ_q      <= 2'd0;
`ifdef TSN_QSCHED_RR_EN
         last_gnt_q <= QID_W'(NUM_Q - 1);
`endif
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         rem_q      <= rem_d;
         inflight_q <= inflight_d;
         tag_last_q <= tag_last_d;
         tag_qid_q  <= tag_qid_d;
         skid_q     <= skid_d;
         hd_q       <= hd_d;
         occ_q      <= occ_d;
`ifdef TSN_QSCHED_RR_EN
         last_gnt_q <= last_gnt_d;
`endif
      end
   end
endmodule

// File: tb/tb_tsn_queue_rd_sched.sv
// Directed bench for tsn_queue_rd_sched with behavioural data (standard) and descriptor (FWFT) FIFO models.
`timescale 1ns/1ps
module tb_tsn_queue_rd_sched;
   localparam int NUM_Q = 4, WIDTH = 64, LEN_W = 12, QID_W = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic [NUM_Q-1:0]       gate = '1;
   logic [NUM_Q-1:0]       len_empty, len_rd, data_empty, data_rd;
   logic [NUM_Q*LEN_W-1:0] len;
   logic [NUM_Q*WIDTH-1:0] data;
   logic                   valid, ready = 1'b1, last, busy, err;
   logic [WIDTH-1:0]       odata;
   logic [QID_W-1:0]       qid;

   always #5 clk = ~clk;

   tsn_queue_rd_sched #(.NUM_Q(NUM_Q), .WIDTH(WIDTH), .LEN_W(LEN_W), .QID_W(QID_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_gate_open(gate), .i_len_empty(len_empty), .i_len(len),
      .o_len_rd(len_rd), .i_data_empty(data_empty), .i_data(data), .o_data_rd(data_rd),
      .o_valid(valid), .i_ready(ready), .o_data(odata), .o_last(last), .o_qid(qid),
      .o_busy(busy), .o_err(err));

   logic [WIDTH-1:0] dmem [NUM_Q][64];
   logic [LEN_W-1:0] lmem [NUM_Q][16];
   logic [WIDTH-1:0] dout [NUM_Q];
   int dwr [NUM_Q];
   int drd [NUM_Q];
   int lwr [NUM_Q];
   int lrd [NUM_Q];

   for (genvar q = 0; q < NUM_Q; q++) begin : g_fifo
      assign len_empty[q]              = (lrd[q] == lwr[q]);
      assign len[q*LEN_W +: LEN_W]     = lmem[q][lrd[q] % 16];
      assign data_empty[q]             = (drd[q] == dwr[q]);
      assign data[q*WIDTH +: WIDTH]    = dout[q];
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int q = 0; q < NUM_Q; q++) begin
            drd[q] <= dwr[q]; lrd[q] <= lwr[q]; dout[q] <= '0;
         end
      end else begin
         for (int q = 0; q < NUM_Q; q++) begin
            if (data_rd[q]) begin dout[q] <= dmem[q][drd[q] % 64]; drd[q] <= drd[q] + 1; end
            if (len_rd[q]) lrd[q] <= lrd[q] + 1;
         end
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [WIDTH-1:0] log_dat [256];
   logic             log_last [256];
   logic [QID_W-1:0] log_qid [256];
   int               log_cyc [256];
   int n_out = 0, err_cnt = 0, onehot_err = 0, stall_err = 0, stall_seen = 0;
   int len_pops [NUM_Q];
   int data_reads [NUM_Q];
   bit prev_stall = 0;
   logic [WIDTH-1:0] p_dat;
   logic p_last;
   logic [QID_W-1:0] p_qid;

   always @(negedge clk) begin
      if (rst_n) begin
         if ($countones(len_rd) > 1 || $countones(data_rd) > 1) onehot_err++;
         for (int q = 0; q < NUM_Q; q++) begin
            if (len_rd[q]) len_pops[q]++;
            if (data_rd[q]) data_reads[q]++;
         end
         if (err) err_cnt++;
         if (prev_stall) begin
            stall_seen++;
            if (!(valid && odata == p_dat && last == p_last && qid == p_qid)) stall_err++;
         end
         prev_stall = valid && !ready;
         p_dat = odata; p_last = last; p_qid = qid;
         if (valid && ready && n_out < 256) begin
            log_dat[n_out] = odata; log_last[n_out] = last; log_qid[n_out] = qid;
            log_cyc[n_out] = cyc; n_out++;
         end
      end else begin
         prev_stall = 0;
      end
   end

   int n_chk = 0, n_fail = 0;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push_word(input int q, input logic [WIDTH-1:0] d);
      dmem[q][dwr[q] % 64] = d;
      dwr[q] = dwr[q] + 1;
   endtask

   task automatic push_desc(input int q, input logic [LEN_W-1:0] l);
      lmem[q][lwr[q] % 16] = l;
      lwr[q] = lwr[q] + 1;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy && ((~len_empty & gate) == '0)) begin ok = 1; break; end
      end
   endtask

   task automatic test_reset();
      tick();
      @(negedge clk);
      n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_chk++; if (len_rd !== 4'b0) begin n_fail++; $display("FAIL reset_len_rd got %b want 0", len_rd); end
      n_chk++; if (data_rd !== 4'b0) begin n_fail++; $display("FAIL reset_data_rd got %b want 0", data_rd); end
      n_chk++; if (err !== 1'b0 || odata !== '0) begin n_fail++; $display("FAIL reset_err_data got %b/%h want 0/0", err, odata); end
   endtask

   task automatic test_priority();
      int b, c0, fq, sq;
      bit ok;
      logic [WIDTH-1:0] exp_d [4];
      tick();
      b = n_out;
      push_word(0, 64'hD0); push_word(0, 64'hD1); push_desc(0, 2);
      push_word(3, 64'hE0); push_word(3, 64'hE1); push_desc(3, 2);
      c0 = cyc;
`ifdef TSN_QSCHED_RR_EN
      fq = 0; sq = 3;
      exp_d[0] = 64'hD0; exp_d[1] = 64'hD1; exp_d[2] = 64'hE0; exp_d[3] = 64'hE1;
`else
      fq = 3; sq = 0;
      exp_d[0] = 64'hE0; exp_d[1] = 64'hE1; exp_d[2] = 64'hD0; exp_d[3] = 64'hD1;
`endif
      wait_idle(60, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL prio_timeout busy=%b want idle", busy); end
      n_chk++; if (n_out - b !== 4) begin n_fail++; $display("FAIL prio_count got %0d want 4", n_out - b); end
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (log_dat[b+i] !== exp_d[i] || log_qid[b+i] !== QID_W'(i < 2 ? fq : sq) || log_last[b+i] !== (i % 2 == 1)) begin
            n_fail++;
            $display("FAIL prio_word%0d got d=%h q=%0d l=%b want d=%h q=%0d l=%b", i, log_dat[b+i],
                     log_qid[b+i], log_last[b+i], exp_d[i], i < 2 ? fq : sq, i % 2 == 1);
         end
      end
      n_chk++; if (log_cyc[b] - c0 !== 2) begin n_fail++; $display("FAIL prio_latency got %0d want 2", log_cyc[b] - c0); end
      n_chk++; if (log_cyc[b+2] - log_cyc[b+1] !== 2) begin n_fail++; $display("FAIL prio_gap got %0d want 2", log_cyc[b+2] - log_cyc[b+1]); end
   endtask

   task automatic test_basic();
      int b, c0, lp, dr;
      bit ok;
      logic [WIDTH-1:0] exp_d [3];
      tick();
      b = n_out; lp = len_pops[1]; dr = data_reads[1];
      exp_d[0] = 64'hA; exp_d[1] = 64'hB; exp_d[2] = 64'hC;
      for (int i = 0; i < 3; i++) push_word(1, exp_d[i]);
      push_desc(1, 3);
      c0 = cyc;
      @(negedge clk);
      n_chk++; if (len_rd !== 4'b0010) begin n_fail++; $display("FAIL basic_len_rd got %b want 0010", len_rd); end
      wait_idle(50, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL basic_timeout busy=%b want idle", busy); end
      n_chk++; if (n_out - b !== 3) begin n_fail++; $display("FAIL basic_count got %0d want 3", n_out - b); end
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if (log_dat[b+i] !== exp_d[i] || log_qid[b+i] !== 2'd1 || log_last[b+i] !== (i == 2) || log_cyc[b+i] !== c0 + 2 + i) begin
            n_fail++;
            $display("FAIL basic_word%0d got d=%h q=%0d l=%b cyc=%0d want d=%h q=1 l=%b cyc=%0d", i, log_dat[b+i],
                     log_qid[b+i], log_last[b+i], log_cyc[b+i], exp_d[i], i == 2, c0 + 2 + i);
         end
      end
      n_chk++; if (len_pops[1] - lp !== 1) begin n_fail++; $display("FAIL basic_len_pops got %0d want 1", len_pops[1] - lp); end
      n_chk++; if (data_reads[1] - dr !== 3) begin n_fail++; $display("FAIL basic_data_reads got %0d want 3", data_reads[1] - dr); end
   endtask

   task automatic test_backpressure();
      int b, dr, se, ss;
      bit ok;
      tick();
      b = n_out; dr = data_reads[2]; se = stall_err; ss = stall_seen;
      for (int i = 0; i < 4; i++) push_word(2, 64'h2000 + 64'(i));
      push_desc(2, 4);
      for (int i = 0; i < 24; i++) begin ready = (i % 2 == 0); tick(); end
      ready = 1'b1;
      wait_idle(40, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_timeout busy=%b want idle", busy); end
      n_chk++; if (n_out - b !== 4) begin n_fail++; $display("FAIL bp_count got %0d want 4", n_out - b); end
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (log_dat[b+i] !== 64'h2000 + 64'(i) || log_qid[b+i] !== 2'd2 || log_last[b+i] !== (i == 3)) begin
            n_fail++;
            $display("FAIL bp_word%0d got d=%h q=%0d l=%b want d=%h q=2 l=%b", i, log_dat[b+i], log_qid[b+i],
                     log_last[b+i], 64'h2000 + 64'(i), i == 3);
         end
      end
      n_chk++; if (data_reads[2] - dr !== 4) begin n_fail++; $display("FAIL bp_data_reads got %0d want 4", data_reads[2] - dr); end
      n_chk++; if (stall_err - se !== 0) begin n_fail++; $display("FAIL bp_stable got %0d unstable stalls want 0", stall_err - se); end
      n_chk++; if (stall_seen - ss < 1) begin n_fail++; $display("FAIL bp_stalls_seen got %0d want >=1", stall_seen - ss); end
   endtask

   task automatic test_zero_len();
      int b, ec, dr;
      bit ok;
      tick();
      b = n_out; ec = err_cnt; dr = data_reads[0];
      push_desc(0, 0);
      @(negedge clk);
      n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL zlen_err got %b want 1", err); end
      n_chk++; if (len_rd !== 4'b0001) begin n_fail++; $display("FAIL zlen_len_rd got %b want 0001", len_rd); end
      n_chk++; if (data_rd !== 4'b0) begin n_fail++; $display("FAIL zlen_data_rd got %b want 0", data_rd); end
      @(negedge clk);
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL zlen_err_pulse got %b want 0", err); end
      wait_idle(20, ok);
      n_chk++; if (!ok || len_empty[0] !== 1'b1) begin n_fail++; $display("FAIL zlen_popped got ok=%b empty=%b want 1/1", ok, len_empty[0]); end
      n_chk++;
      if (err_cnt - ec !== 1 || data_reads[0] - dr !== 0 || n_out - b !== 0) begin
         n_fail++;
         $display("FAIL zlen_totals got err=%0d rd=%0d out=%0d want 1/0/0", err_cnt - ec, data_reads[0] - dr, n_out - b);
      end
   endtask

   task automatic test_gate();
      int b, lp;
      bit ok;
      tick();
      b = n_out; lp = len_pops[1];
      gate[1] = 1'b0;
      push_word(1, 64'h11); push_desc(1, 1);
      push_word(0, 64'h10); push_desc(0, 1);
      wait_idle(30, ok);
      n_chk++; if (!ok || n_out - b !== 1) begin n_fail++; $display("FAIL gate_count got ok=%b n=%0d want 1/1", ok, n_out - b); end
      n_chk++; if (log_qid[b] !== 2'd0 || log_dat[b] !== 64'h10) begin n_fail++; $display("FAIL gate_q0 got q=%0d d=%h want 0/10", log_qid[b], log_dat[b]); end
      n_chk++; if (len_pops[1] - lp !== 0 || len_empty[1] !== 1'b0) begin n_fail++; $display("FAIL gate_q1_held got pops=%0d empty=%b want 0/0", len_pops[1] - lp, len_empty[1]); end
      tick();
      gate[1] = 1'b1;
      wait_idle(30, ok);
      n_chk++; if (!ok || log_qid[b+1] !== 2'd1 || log_dat[b+1] !== 64'h11) begin n_fail++; $display("FAIL gate_q1_open got ok=%b q=%0d d=%h want 1/1/11", ok, log_qid[b+1], log_dat[b+1]); end
   endtask

   task automatic test_stall();
      int b, dr;
      bit ok;
      tick();
      b = n_out; dr = data_reads[1];
      push_word(1, 64'h500); push_word(1, 64'h501); push_desc(1, 5);
      repeat (12) tick();
      n_chk++; if (n_out - b !== 2 || data_reads[1] - dr !== 2) begin n_fail++; $display("FAIL stall_partial got out=%0d rd=%0d want 2/2", n_out - b, data_reads[1] - dr); end
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy got %b want 1", busy); end
      for (int i = 2; i < 5; i++) push_word(1, 64'h500 + 64'(i));
      wait_idle(40, ok);
      n_chk++; if (!ok || n_out - b !== 5) begin n_fail++; $display("FAIL stall_count got ok=%b n=%0d want 1/5", ok, n_out - b); end
      for (int i = 0; i < 5; i++) begin
         n_chk++;
         if (log_dat[b+i] !== 64'h500 + 64'(i) || log_last[b+i] !== (i == 4) || log_qid[b+i] !== 2'd1) begin
            n_fail++;
            $display("FAIL stall_word%0d got d=%h l=%b q=%0d want d=%h l=%b q=1", i, log_dat[b+i], log_last[b+i],
                     log_qid[b+i], 64'h500 + 64'(i), i == 4);
         end
      end
   endtask

   task automatic test_reset_mid();
      int b, c0;
      bit ok;
      tick();
      ready = 1'b0;
      for (int i = 0; i < 4; i++) push_word(2, 64'h700 + 64'(i));
      push_desc(2, 4);
      repeat (5) tick();
      n_chk++; if (valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got v=%b b=%b want 1/1", valid, busy); end
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (valid !== 1'b0 || busy !== 1'b0 || odata !== '0) begin n_fail++; $display("FAIL rmid_async got v=%b b=%b d=%h want 0/0/0", valid, busy, odata); end
      n_chk++; if (data_rd !== 4'b0 || len_rd !== 4'b0 || last !== 1'b0) begin n_fail++; $display("FAIL rmid_rd got drd=%b lrd=%b l=%b want 0/0/0", data_rd, len_rd, last); end
      repeat (2) tick();
      rst_n = 1'b1;
      ready = 1'b1;
      @(negedge clk);
      n_chk++; if (busy !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL rmid_idle got b=%b v=%b want 0/0", busy, valid); end
      tick();
      b = n_out;
      push_word(1, 64'h900); push_desc(1, 1);
      c0 = cyc;
      wait_idle(30, ok);
      n_chk++;
      if (!ok || n_out - b !== 1 || log_dat[b] !== 64'h900 || log_cyc[b] - c0 !== 2 || log_last[b] !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_after got ok=%b n=%0d d=%h lat=%0d l=%b want 1/1/900/2/1", ok, n_out - b, log_dat[b], log_cyc[b] - c0, log_last[b]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      test_reset();
      test_priority();
      test_basic();
      test_backpressure();
      test_zero_len();
      test_gate();
      test_stall();
      test_reset_mid();
      n_chk++; if (onehot_err !== 0) begin n_fail++; $display("FAIL onehot got %0d violations want 0", onehot_err); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
